dmem_arbiter: RTL
=================

# dmem_arbiter

Two-port arbiter and sequencer for the single-port data SPRAM behind the data cache. It lets two requesters share one word-wide memory port: port 0 is the CPU load/store path and port 1 is the debug/loader path. Each request is serialised into one memory access with correct single-port read latency, and completion is returned as a one-cycle ack. Fairness is round-robin, so neither port is starved.

## Interface
Parameters:
- ADDR_WIDTH, 10, word address width (SPRAM depth used by the data region)

Ports:
- clk  in  1  system clock; all state changes on rising edge
- rst  in  1  reset, asynchronous, active-high
- r0_req  in  1  port 0 request; held stable until r0_ack
- r0_we  in  1  port 0 write (1) / read (0)
- r0_addr  in  ADDR_WIDTH  port 0 word address
- r0_wdata  in  32  port 0 write data
- r0_be  in  4  port 0 byte write enables; bit i = byte i
- r0_ack  out  1  port 0 completion pulse, one cycle
- r0_rdata  out  32  port 0 read data, valid from the r0_ack cycle onward
- r1_req, r1_we, r1_addr, r1_wdata, r1_be, r1_ack, r1_rdata: same as port 0, for port 1
- mem_cs  out  1  memory chip select; high exactly one cycle per access
- mem_we  out  1  memory write enable; qualified by mem_cs
- mem_addr  out  ADDR_WIDTH  memory word address
- mem_wdata  out  32  memory write data
- mem_be  out  4  memory byte mask; equals granted be on writes, 4'b0000 on reads
- mem_rdata  in  32  memory read data; valid the cycle after the read edge
- busy  out  1  high whenever the state is not IDLE

## Operation
- States: IDLE, ACCESS, READ_WAIT, DONE. Internal last_grant bit.
- IDLE:
  - No req: stay in IDLE.
  - One req: grant that port.
  - Both req: grant the port not equal to last_grant.
  - On grant: register mem_addr/mem_wdata/mem_be/mem_we from the granted port, set mem_cs=1, update last_grant, go to ACCESS.
- ACCESS: the memory performs the access on the closing edge. At that edge mem_cs and mem_we go to 0.
  - Write: assert the granted port's ack, go to DONE.
  - Read: go to READ_WAIT.
- READ_WAIT: on the closing edge, capture mem_rdata into the granted port's rdata, assert its ack, go to DONE.
- DONE: ack goes to 0, go to IDLE. Requests are not sampled in DONE. This lets the requester drop or replace req at the end of its ack cycle without a double issue.
- rX_rdata changes only on a completed read for port X. Otherwise it holds its value, including across the other port's reads.
- be=4'b0000 on a write is still a full transaction: one mem_cs pulse, then ack, with no bytes changed.
- A req dropped by the requester before ack is a protocol violation. Behaviour is undefined; the bench checks it as an assertion.

## Timing
- Reset (rst=1, at any time, including mid-transaction):
  - State goes to IDLE immediately.
  - mem_cs, mem_we, r0_ack, r1_ack, busy = 0.
  - mem_addr, mem_wdata, mem_be, r0_rdata, r1_rdata = 0.
  - last_grant = 1, so port 0 wins the first tie.
  - The in-flight access is dropped with no ack. The first sample after release is the first rising edge with rst low.
- Write latency: req sampled at edge E0; mem_cs high in cycle E0..E1; ack high in cycle E1..E2; IDLE again from E2. Occupancy is 3 cycles.
- Read latency: sampled at E0; mem_cs high E0..E1; data captured at E2; ack high E2..E3. Occupancy is 4 cycles.
- Sustained throughput with both ports always requesting: strict alternation 0,1,0,1. Maximum wait for a pending port is one other transaction (at most 4 cycles) plus its own.
- mem_* outputs are all registered; there is no combinational path from rX_* inputs to mem_* or to ack.

## Test plan
- Reset mid-read: assert rst during READ_WAIT of a port 0 read. Required: all outputs 0 in the same cycle, no r0_ack, busy=0. After release, a fresh read completes normally.
- Single write then read: port 0 writes addr 0x005, data 0xDEADBEEF, be 0xF. Required: mem_cs is a single 1-cycle pulse with mem_be=0xF; r0_ack arrives 2 cycles after the sampling edge. A read of 0x005 returns r0_rdata=0xDEADBEEF with ack 3 cycles after sampling and mem_be=0.
- Byte write: word 0x00A holds 0x11223344; port 1 writes be=0x4, data 0x00AB0000. Required: readback 0x11AB3344.
- Tie after reset: both ports request in the same cycle. Required: port 0 is granted first, then port 1. Over 4 continuous requests per port the grant order is 0,1,0,1,0,1,0,1, and there is no mem_cs in DONE cycles.
- Data isolation: port 1 reads 0xCAFEF00D, then port 0 performs 3 reads of other data. Required: r1_rdata stays 0xCAFEF00D, and r1_ack fires exactly once.
- Zero-mask write: port 0 write with be=0x0. Required: one mem_cs pulse with mem_we=1 and mem_be=0, r0_ack asserted, and memory contents unchanged on readback.

Source files
------------

// File: rtl/dmem_arbiter.sv
// dmem_arbiter: round-robin two-port sequencer for a single-port data SPRAM
module dmem_arbiter #(
  parameter int ADDR_WIDTH = 10
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  r0_req,
  input  logic                  r0_we,
  input  logic [ADDR_WIDTH-1:0] r0_addr,
  input  logic [31:0]           r0_wdata,
  input  logic [3:0]            r0_be,
  output logic                  r0_ack,
  output logic [31:0]           r0_rdata,
  input  logic                  r1_req,
  input  logic                  r1_we,
  input  logic [ADDR_WIDTH-1:0] r1_addr,
  input  logic [31:0]           r1_wdata,
  input  logic [3:0]            r1_be,
  output logic                  r1_ack,
  output logic [31:0]           r1_rdata,
  output logic                  mem_cs,
  output logic                  mem_we,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [31:0]           mem_wdata,
  output logic [3:0]            mem_be,
  input  logic [31:0]           mem_rdata,
  output logic                  busy
);
  typedef enum logic [1:0] {IDLE, ACCESS, READ_WAIT, DONE} state_t;
  state_t state, state_nx;
  logic gnt, last_grant, sel, grant, ack_set, sel_we;
  always_comb begin
    sel = (r0_req && r1_req) ? !last_grant : r1_req;
    sel_we = sel ? r1_we : r0_we;
    grant = (state == IDLE) && (r0_req || r1_req);
    ack_set = (state == ACCESS && mem_we) || state == READ_WAIT;
    state_nx = state == IDLE ? (grant ? ACCESS : IDLE) :
               state == ACCESS ? (mem_we ? DONE : READ_WAIT) :
               state == READ_WAIT ? DONE : IDLE;
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) state <= IDLE;
    else state <= state_nx;
  assign busy = state != IDLE;
  // Requests are only sampled in IDLE, so the DONE cycle gives the requester time to drop req
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      gnt <= 1'b0;
      last_grant <= 1'b1;
      mem_cs <= 1'b0;
      mem_we <= 1'b0;
      mem_addr <= '0;
      mem_wdata <= '0;
      mem_be <= '0;
      r0_ack <= 1'b0;
      r1_ack <= 1'b0;
      r0_rdata <= '0;
      r1_rdata <= '0;
    end else begin
      r0_ack <= ack_set && !gnt;
      r1_ack <= ack_set && gnt;
      if (grant) begin
        gnt <= sel;
        last_grant <= sel;
        mem_cs <= 1'b1;
        mem_we <= sel_we;
        mem_addr <= sel ? r1_addr : r0_addr;
        mem_wdata <= sel ? r1_wdata : r0_wdata;
        mem_be <= sel_we ? (sel ? r1_be : r0_be) : 4'b0000;
      end else if (state == ACCESS) begin
        mem_cs <= 1'b0;
        mem_we <= 1'b0;
      end
      if (state == READ_WAIT && !gnt) r0_rdata <= mem_rdata;
      if (state == READ_WAIT && gnt) r1_rdata <= mem_rdata;
    end
endmodule
